// File: rtl/shf_ctl_pkg.sv
// Shared opcode, shifter class and FSM state definitions for the shifter
// controller slice.
package shf_ctl_pkg;

    localparam logic [2:0] OP_SHF = 3'b000;
    localparam logic [2:0] OP_ROT = 3'b001;
    localparam logic [2:0] OP_CLZ = 3'b010;
    localparam logic [2:0] OP_CLO = 3'b011;
    localparam logic [2:0] OP_NRM = 3'b100;

    // A count of 16 from the leading-bit counter means every bit matched.
    localparam logic [4:0] NRM_FULL = 5'd16;

    typedef enum logic [1:0] {
        CLS_SHF = 2'b00,
        CLS_ROT = 2'b01,
        CLS_CLZ = 2'b10,
        CLS_CLO = 2'b11
    } shf_cls_t;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ISS1 = 3'd1,
        CAP1 = 3'd2,
        ISS2 = 3'd3,
        CAP2 = 3'd4,
        DONE = 3'd5
    } state_t;

    function automatic logic op_legal(input logic [2:0] op);
        return op <= OP_NRM;
    endfunction

endpackage

// File: rtl/shf_ctl_rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins
// the next contention and moves only when a grant is taken (adv).
module rr_arb2
    import shf_ctl_pkg::*;
(
    input  logic       clk_exe,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       adv,
    output logic [1:0] gnt,
    output logic       id
);

    logic ptr;

    always_comb begin
        id = 1'b0;
        if (req == 2'b11)
            id = ptr;
        else if (req[1])
            id = 1'b1;
        gnt = '0;
        if (req != 2'b00)
            gnt = id ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk_exe or negedge reset) begin
        if (!reset)
            ptr <= 1'b0;
        else if (adv)
            ptr <= ~id;
    end

endmodule

// File: rtl/shf_ctl.sv
// Shifter controller: arbitrates two requesters and sequences one or two
// passes through an external shifter per operation.
module shf_ctl
    import shf_ctl_pkg::*;
#(
    parameter int DATASIZE = 16
) (
    input  logic                clk_exe,
    input  logic                reset,
    input  logic                req0,
    input  logic                req1,
    input  logic [2:0]          op0,
    input  logic [2:0]          op1,
    input  logic [DATASIZE-1:0] x0,
    input  logic [DATASIZE-1:0] x1,
    input  logic [DATASIZE-1:0] y0,
    input  logic [DATASIZE-1:0] y1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                busy,
    output logic                rsp_vld,
    output logic                rsp_id,
    output logic [DATASIZE-1:0] rsp_dt,
    output logic                rsp_sv,
    output logic                rsp_sz,
    output logic [4:0]          rsp_exp,
    output logic                ps_shf_en,
    output logic [1:0]          ps_shf_cls,
    output logic [DATASIZE-1:0] xb_dtx,
    output logic [DATASIZE-1:0] xb_dty,
    input  logic [DATASIZE-1:0] shf_xb_dt,
    input  logic                shf_ps_sv,
    input  logic                shf_ps_sz
);

    state_t              state;
    logic [2:0]          op_r;
    logic [DATASIZE-1:0] x_r;
    logic                id_r;
    logic [4:0]          exp_r;

    logic                idle;
    logic                adv;
    logic [1:0]          arb_gnt;
    logic                arb_id;
    logic [2:0]          sel_op;
    logic [DATASIZE-1:0] sel_x;
    logic [DATASIZE-1:0] sel_y;
    logic [4:0]          cnt;

    assign idle   = (state == IDLE);
    assign adv    = idle & (req0 | req1);
    assign busy   = ~idle;
    assign gnt0   = idle & arb_gnt[0];
    assign gnt1   = idle & arb_gnt[1];
    assign sel_op = arb_id ? op1 : op0;
    assign sel_x  = arb_id ? x1 : x0;
    assign sel_y  = arb_id ? y1 : y0;
    assign cnt    = shf_xb_dt[4:0];

    rr_arb2 u_arb (
        .clk_exe (clk_exe),
        .reset   (reset),
        .req     ({req1, req0}),
        .adv     (adv),
        .gnt     (arb_gnt),
        .id      (arb_id)
    );

    always_ff @(posedge clk_exe or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            op_r       <= '0;
            x_r        <= '0;
            id_r       <= 1'b0;
            exp_r      <= '0;
            rsp_vld    <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_dt     <= '0;
            rsp_sv     <= 1'b0;
            rsp_sz     <= 1'b0;
            rsp_exp    <= '0;
            ps_shf_en  <= 1'b0;
            ps_shf_cls <= '0;
            xb_dtx     <= '0;
            xb_dty     <= '0;
        end else begin
            rsp_vld   <= 1'b0;
            ps_shf_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (adv) begin
                        op_r <= sel_op;
                        x_r  <= sel_x;
                        id_r <= arb_id;
                        if (!op_legal(sel_op)) begin
                            rsp_dt  <= '0;
                            rsp_sv  <= 1'b1;
                            rsp_sz  <= 1'b0;
                            rsp_exp <= '0;
                            rsp_id  <= arb_id;
                            rsp_vld <= 1'b1;
                            state   <= DONE;
                        end else begin
                            ps_shf_en <= 1'b1;
                            xb_dtx    <= sel_x;
                            xb_dty    <= sel_y;
                            if (sel_op == OP_NRM)
                                ps_shf_cls <= sel_x[15] ? CLS_CLO : CLS_CLZ;
                            else
                                ps_shf_cls <= sel_op[1:0];
                            state <= ISS1;
                        end
                    end
                end
                ISS1: state <= CAP1;
                CAP1: begin
                    if (op_r == OP_NRM && cnt == NRM_FULL) begin
                        // All bits equal the sign: nothing to normalize.
                        rsp_dt  <= x_r;
                        rsp_sv  <= 1'b1;
                        rsp_sz  <= (x_r == '0);
                        rsp_exp <= NRM_FULL;
                        rsp_id  <= id_r;
                        rsp_vld <= 1'b1;
                        state   <= DONE;
                    end else if (op_r == OP_NRM) begin
                        // Shift by one less than the count to keep a sign bit.
                        ps_shf_en  <= 1'b1;
                        ps_shf_cls <= CLS_SHF;
                        xb_dtx     <= x_r;
                        xb_dty     <= DATASIZE'(cnt - 5'd1);
                        exp_r      <= cnt - 5'd1;
                        state      <= ISS2;
                    end else begin
                        rsp_dt  <= shf_xb_dt;
                        rsp_sv  <= shf_ps_sv;
                        rsp_sz  <= shf_ps_sz;
                        rsp_exp <= '0;
                        rsp_id  <= id_r;
                        rsp_vld <= 1'b1;
                        state   <= DONE;
                    end
                end
                ISS2: state <= CAP2;
                CAP2: begin
                    rsp_dt  <= shf_xb_dt;
                    rsp_sv  <= shf_ps_sv;
                    rsp_sz  <= shf_ps_sz;
                    rsp_exp <= exp_r;
                    rsp_id  <= id_r;
                    rsp_vld <= 1'b1;
                    state   <= DONE;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shf_ctl.sv
// Bench for shf_ctl: behavioural shifter on the shifter port and a
// reference model of the complete operation results.
module tb_shf_ctl;

    localparam int DW = 16;

    logic          clk_exe = 1'b0;
    logic          reset   = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0;
    logic [2:0]    op0 = '0, op1 = '0;
    logic [DW-1:0] x0 = '0, x1 = '0, y0 = '0, y1 = '0;
    logic          gnt0, gnt1, busy, rsp_vld, rsp_id, rsp_sv, rsp_sz, ps_shf_en;
    logic [DW-1:0] rsp_dt, xb_dtx, xb_dty;
    logic [4:0]    rsp_exp;
    logic [1:0]    ps_shf_cls;
    logic [DW-1:0] shf_xb_dt = '0;
    logic          shf_ps_sv = 1'b0, shf_ps_sz = 1'b0;

    int checks   = 0;
    int failures = 0;

    always #5 clk_exe = ~clk_exe;

    shf_ctl #(.DATASIZE(DW)) dut (
        .clk_exe    (clk_exe),
        .reset      (reset),
        .req0       (req0),
        .req1       (req1),
        .op0        (op0),
        .op1        (op1),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .busy       (busy),
        .rsp_vld    (rsp_vld),
        .rsp_id     (rsp_id),
        .rsp_dt     (rsp_dt),
        .rsp_sv     (rsp_sv),
        .rsp_sz     (rsp_sz),
        .rsp_exp    (rsp_exp),
        .ps_shf_en  (ps_shf_en),
        .ps_shf_cls (ps_shf_cls),
        .xb_dtx     (xb_dtx),
        .xb_dty     (xb_dty),
        .shf_xb_dt  (shf_xb_dt),
        .shf_ps_sv  (shf_ps_sv),
        .shf_ps_sz  (shf_ps_sz)
    );

    // Number of leading bits of v equal to b.
    function automatic int lead_cnt(input logic [15:0] v, input logic b);
        int c = 0;
        logic run = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            if (run && v[i] == b) c++;
            else run = 1'b0;
        end
        return c;
    endfunction

    // {sv, sz, result}: positive s shifts left, negative shifts right arithmetically.
    function automatic logic [17:0] shift_ref(input logic [15:0] v, input int s);
        logic [15:0] r;
        logic        ov;
        if (s >= 16) begin
            r = '0; ov = (v != 16'h0);
        end else if (s >= 0) begin
            r = v << s; ov = (($signed(r) >>> s) != $signed(v));
        end else if (s <= -16) begin
            r = {16{v[15]}}; ov = 1'b0;
        end else begin
            r = $signed(v) >>> (-s); ov = 1'b0;
        end
        return {ov, (r == 16'h0), r};
    endfunction

    function automatic logic [15:0] rot_ref(input logic [15:0] v, input logic [15:0] y);
        int a = int'(y[3:0]);
        return (v << a) | (v >> (16 - a));
    endfunction

    function automatic logic [17:0] env_shf(input logic [1:0] cls, input logic [15:0] x,
                                            input logic [15:0] y);
        logic [15:0] r;
        case (cls)
            2'b00:   return shift_ref(x, int'($signed(y)));
            2'b01:   begin r = rot_ref(x, y);           return {1'b0, (r == 16'h0), r}; end
            2'b10:   begin r = 16'(lead_cnt(x, 1'b0));  return {1'b0, (r == 16'h0), r}; end
            default: begin r = 16'(lead_cnt(x, 1'b1));  return {1'b0, (r == 16'h0), r}; end
        endcase
    endfunction

    always @(posedge clk_exe) begin
        if (ps_shf_en)
            {shf_ps_sv, shf_ps_sz, shf_xb_dt} <= env_shf(ps_shf_cls, xb_dtx, xb_dty);
    end

    // Expected response of a whole operation; lat=0 means latency not checked.
    task automatic ref_op(input logic [2:0] op, input logic [15:0] x, input logic [15:0] y,
                          output logic [15:0] dt, output logic sv, output logic sz,
                          output logic [4:0] ex, output int lat, output logic [1:0] cls1);
        logic [17:0] t;
        int c;
        ex = '0; lat = 3; cls1 = op[1:0];
        case (op)
            3'd0: t = shift_ref(x, int'($signed(y)));
            3'd1: t = {1'b0, (rot_ref(x, y) == 16'h0), rot_ref(x, y)};
            3'd2: begin c = lead_cnt(x, 1'b0); t = {1'b0, (c == 0), 16'(c)}; end
            3'd3: begin c = lead_cnt(x, 1'b1); t = {1'b0, (c == 0), 16'(c)}; end
            3'd4: begin
                c = lead_cnt(x, x[15]);
                cls1 = x[15] ? 2'b11 : 2'b10;
                if (c == 16) begin
                    t = {1'b1, (x == 16'h0), x}; ex = 5'd16; lat = 0;
                end else begin
                    t = shift_ref(x, c - 1); ex = 5'(c - 1); lat = 5;
                end
            end
            default: begin t = {1'b1, 1'b0, 16'h0}; lat = 1; end
        endcase
        {sv, sz, dt} = t;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for its grant and check the complete response.
    task automatic do_op(input logic who, input logic [2:0] op, input logic [15:0] x,
                         input logic [15:0] y);
        logic [15:0] edt;
        logic        esv, esz, got;
        logic [4:0]  eex;
        logic [1:0]  ecls;
        int          elat, lat;
        ref_op(op, x, y, edt, esv, esz, eex, elat, ecls);
        if (!who) begin req0 = 1'b1; op0 = op; x0 = x; y0 = y; end
        else      begin req1 = 1'b1; op1 = op; x1 = x; y1 = y; end
        #1;
        got = 1'b0;
        for (int n = 0; n < 20 && !got; n++) begin
            got = who ? gnt1 : gnt0;
            if (!got) begin @(negedge clk_exe); #1; end
        end
        chk("grant", got, 1);
        @(posedge clk_exe); #1;
        if (!who) req0 = 1'b0; else req1 = 1'b0;
        if (!got) return;
        lat = 0;
        for (int k = 1; k <= 8 && lat == 0; k++) begin
            @(negedge clk_exe);
            if (k == 1) begin
                chk("busy", busy, 1);
                if (elat == 1) chk("no_shf_access", ps_shf_en, 0);
                else begin
                    chk("iss1_en", ps_shf_en, 1);
                    chk("iss1_cls", ps_shf_cls, ecls);
                    chk("iss1_dtx", xb_dtx, x);
                    if (op != 3'd4) chk("iss1_dty", xb_dty, y);
                end
            end
            if (k == 3 && op == 3'd4 && elat == 5) begin
                chk("iss2_en", ps_shf_en, 1);
                chk("iss2_cls", ps_shf_cls, 0);
                chk("iss2_dty", xb_dty, 16'(eex));
            end
            if (rsp_vld) lat = k;
        end
        chk("rsp_vld_seen", (lat != 0), 1);
        if (elat != 0) chk("latency", lat, elat);
        chk("rsp_id", rsp_id, who);
        chk("rsp_dt", rsp_dt, edt);
        chk("rsp_sv", rsp_sv, esv);
        chk("rsp_sz", rsp_sz, esz);
        chk("rsp_exp", rsp_exp, eex);
        @(negedge clk_exe);
        chk("vld_pulse_end", rsp_vld, 0);
        chk("back_idle", busy, 0);
        chk("rsp_dt_hold", rsp_dt, edt);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        logic [2:0]  rop;
        logic [15:0] rx, ry;

        // Reset state
        repeat (2) @(negedge clk_exe);
        chk("rst_busy", busy, 0);
        chk("rst_vld", rsp_vld, 0);
        chk("rst_dt", rsp_dt, 0);
        chk("rst_exp", rsp_exp, 0);
        chk("rst_en", ps_shf_en, 0);
        chk("rst_cls", ps_shf_cls, 0);
        chk("rst_dtx", xb_dtx, 0);
        chk("rst_dty", xb_dty, 0);
        chk("rst_gnt", {gnt1, gnt0}, 0);
        reset = 1'b1;
        @(negedge clk_exe);

        // Contention after reset: requester 0 first, illegal op done in cycle 1
        req0 = 1'b1; op0 = 3'b110; x0 = 16'h1234;
        req1 = 1'b1; op1 = 3'b000; x1 = 16'hF000; y1 = 16'hFFFC;
        #1;
        chk("cont_gnt0", gnt0, 1);
        chk("cont_gnt1", gnt1, 0);
        @(posedge clk_exe); #1;
        req0 = 1'b0;
        @(negedge clk_exe);
        chk("ill_vld_c1", rsp_vld, 1);
        chk("ill_dt", rsp_dt, 0);
        chk("ill_sv", rsp_sv, 1);
        chk("ill_sz", rsp_sz, 0);
        chk("ill_id", rsp_id, 0);
        chk("wait_no_gnt", gnt1, 0);
        do_op(1'b1, 3'b000, 16'hF000, 16'hFFFC);

        // Directed operations
        do_op(1'b0, 3'b000, 16'hF000, 16'hFFFC);
        do_op(1'b1, 3'b001, 16'hC000, 16'h0002);
        do_op(1'b0, 3'b100, 16'h0030, 16'h5555);
        do_op(1'b0, 3'b100, 16'hFFA0, 16'h0000);
        do_op(1'b0, 3'b100, 16'h0000, 16'h0000);
        do_op(1'b1, 3'b100, 16'hFFFF, 16'h0000);
        do_op(1'b0, 3'b010, 16'h0001, 16'h0000);
        do_op(1'b1, 3'b011, 16'hFFFF, 16'h0000);
        do_op(1'b0, 3'b000, 16'h4001, 16'h0001);
        do_op(1'b1, 3'b111, 16'hABCD, 16'h0000);

        // Reset during CAP1 of a normalize
        req0 = 1'b1; op0 = 3'b100; x0 = 16'h0030;
        #1;
        chk("mid_gnt", gnt0, 1);
        @(posedge clk_exe); #1;
        req0 = 1'b0;
        repeat (2) @(negedge clk_exe);
        chk("mid_busy_cap1", busy, 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_vld", rsp_vld, 0);
        chk("mid_rst_dt", rsp_dt, 0);
        chk("mid_rst_en", ps_shf_en, 0);
        @(negedge clk_exe);
        reset = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk_exe);
            if (rsp_vld || busy) seen++;
        end
        chk("mid_discarded", seen, 0);
        do_op(1'b0, 3'b100, 16'h0030, 16'h0000);

        // Randomized operations
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            rx  = 16'($urandom);
            ry  = 16'($urandom);
            if (rop == 3'd0) ry = 16'(int'($urandom_range(0, 40)) - 20);
            if (rop == 3'd4 && $urandom_range(0, 5) == 0) rx = $urandom_range(0, 1) ? 16'hFFFF : 16'h0000;
            do_op(1'($urandom_range(0, 1)), rop, rx, ry);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shf_ctl.md
SHF_CTL -- requirements
Module: shf_ctl

Interface
REQ-001 Parameter: DATASIZE, default 16, operand/result width; the normalize count logic is fixed at 16 bits.
REQ-002 clk_exe  input  1  execution clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low.
REQ-004 req0/req1  input  1 each  operation request from requester 0/1; held until granted.
REQ-005 op0/op1  input  3 each  opcode: 000 shift, 001 rotate, 010 count-leading-zeros, 011 count-leading-ones, 100 normalize, 101-111 illegal.
REQ-006 x0/x1, y0/y1  input  DATASIZE each  operands; y is ignored for ops 010/011/100.
REQ-007 gnt0/gnt1  output  1 each  combinational one-cycle accept pulse.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 rsp_vld  output  1  one-cycle completion pulse.
REQ-010 rsp_id  output  1  requester that owns the response.
REQ-011 rsp_dt  output  DATASIZE  result data.
REQ-012 rsp_sv, rsp_sz  output  1 each  overflow and zero flags.
REQ-013 rsp_exp  output  5  normalize shift count; 0 for all other ops.
REQ-014 ps_shf_en  output  1  shifter capture enable.
REQ-015 ps_shf_cls  output  2  shifter class.
REQ-016 xb_dtx, xb_dty  output  DATASIZE each  shifter operands.
REQ-017 shf_xb_dt  input  DATASIZE  shifter result.
REQ-018 shf_ps_sv, shf_ps_sz  input  1 each  shifter overflow and zero flags.

Function
REQ-019 FSM states SHALL be IDLE, ISS1, CAP1, ISS2, CAP2, DONE; only IDLE accepts requests.
REQ-020 In IDLE, with at least one req, the block SHALL grant one requester and latch its op, x and y; the next state is ISS1, or DONE for an illegal op.
REQ-021 Arbitration SHALL be round-robin: on contention, grant the requester not granted last; the pointer favours requester 0 after reset.
REQ-022 ps_shf_en SHALL be 1 only in ISS1 and ISS2; cls/dtx/dty SHALL be driven from latched registers and hold value otherwise.
REQ-023 ISS1 drive for ops 000/001/010/011: cls = op[1:0], dtx = x, dty = y.
REQ-024 ISS1 drive for normalize: cls = 10 if x[15]=0, else 11; dtx = x.
REQ-025 CAP1/CAP2 SHALL register shf_xb_dt, shf_ps_sv and shf_ps_sz, i.e. the result one cycle after capture.
REQ-026 Single ops SHALL follow IDLE -> ISS1 -> CAP1 -> DONE, with rsp_vld high in cycle 3 after the grant cycle.
REQ-027 Normalize, with count c = shf_xb_dt[4:0] at CAP1:
- if c = 16: skip to DONE with rsp_dt = x, rsp_sv = 1, rsp_sz = (x==0), rsp_exp = 16;
- otherwise: ISS2 with cls = 00, dtx = x, dty = c-1, then CAP2 -> DONE, with rsp_exp = c-1 and the flags taken from the shifter;
- rsp_vld SHALL be high in cycle 5.
REQ-028 Illegal ops SHALL complete via DONE in cycle 1 with rsp_dt = 0, rsp_sv = 1, rsp_sz = 0, and no shifter access.
REQ-029 DONE SHALL pulse rsp_vld for exactly 1 cycle, then return to IDLE; rsp_* hold their values until the next DONE.
REQ-030 A req arriving while busy SHALL wait; gnt SHALL never assert outside IDLE.

Reset
REQ-031 Reset SHALL take the FSM to IDLE and clear the arbiter pointer, ps_shf_en, gnt*, rsp_vld, rsp_id, rsp_dt, rsp_sv, rsp_sz, rsp_exp, cls, dtx and dty.
REQ-032 Reset mid-operation SHALL discard the in-flight op: no rsp_vld, and no retry.

Structure
REQ-033 Package shf_ctl_pkg SHALL hold the opcode constants, shifter class codes (SHF/ROT/CLZ/CLO) and FSM state encoding.
REQ-034 Round-robin selection SHALL be the sub-module rr_arb2, with inputs req[1:0] and adv and outputs gnt[1:0] and id; the pointer updates on adv.

Verification
REQ-035 op0=000, x=F000, y=FFFC -> rsp_dt=FF00, sv=0, sz=0, rsp_vld in cycle 3.
REQ-036 op1=001, x=C000, y=0002 -> rsp_dt=0003, rsp_id=1, sz=0.
REQ-037 op0=100, x=0030 -> ISS1 cls=10, ISS2 dty=0009 -> rsp_dt=6000, rsp_exp=9, rsp_vld in cycle 5.
REQ-038 op0=100, x=FFA0 -> cls=11, rsp_dt=A000, rsp_exp=8; op=100, x=0000 -> rsp_dt=0000, sv=1, sz=1, exp=16.
REQ-039 req0 and req1 both held after reset -> gnt0 first, gnt1 on the next IDLE; op=110 -> rsp_dt=0, sv=1 in cycle 1.
REQ-040 reset asserted in CAP1 of a normalize -> IDLE, no rsp_vld; a new request after release completes normally.
